// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared types, sizing helpers and saturation bounds for
// matrix_mult_stream and its MAC unit.
//   state_e      - job FSM states
//   acc_w()      - accumulator width that cannot overflow for a MAX_DIM dot product
//   dim_w()      - width of a dimension field (must hold MAX_DIM itself)
//   sat_hi/lo()  - clamp bounds for a DW-bit result, signed or unsigned
package matrix_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_e;

  function automatic int acc_w(input int dw, input int max_dim);
    return 2*dw + $clog2(max_dim);
  endfunction

  function automatic int dim_w(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  localparam int DIM_W_DEFAULT = dim_w(8);

  function automatic longint sat_hi(input int dw, input bit sgn);
    if (sgn) return (longint'(1) << (dw-1)) - 1;
    return (longint'(1) << dw) - 1;
  endfunction

  function automatic longint sat_lo(input int dw, input bit sgn);
    if (sgn) return -(longint'(1) << (dw-1));
    return 0;
  endfunction

endpackage

// File: rtl/matrix_mult_stream_mac_unit.sv
// mac_unit: multiply-accumulate with synchronous clear and enable.
//   clk_i, reset_i  - clock, synchronous active-high reset
//   clr_i           - load accumulator with zero (wins over en_i)
//   en_i            - add a_i*b_i to the accumulator
//   a_i, b_i        - DW-bit operands (two's complement when SIGNED)
//   acc_o           - ACC_W-bit accumulator register
module mac_unit #(
  parameter int DW     = 8,
  parameter int ACC_W  = 19,
  parameter int SIGNED = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] a_x, b_x, prod;
  logic [ACC_W-1:0] acc_q;

  // Extending to ACC_W before multiplying keeps the low ACC_W product bits
  // exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {{(ACC_W-DW){a_i[DW-1]}}, a_i};
      b_x = {{(ACC_W-DW){b_i[DW-1]}}, b_i};
    end else begin
      a_x = {{(ACC_W-DW){1'b0}}, a_i};
      b_x = {{(ACC_W-DW){1'b0}}, b_i};
    end
    prod = a_x * b_x;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)   acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_q + prod;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream: runtime-sized C = A x B (A is MxK, B is KxN).
// Operands stream in row-major (all of A, then all of B) over in_*; one MAC
// fills C row-major; C streams out over out_* after shift and saturation.
//   clk_i, reset_i            - clock, synchronous active-high reset
//   start_i                   - begin job (only looked at in IDLE)
//   dim_m_i/dim_k_i/dim_n_i   - job dimensions, 1..MAX_DIM
//   shift_i, sat_en_i         - post-process controls, latched at start
//   in_valid_i/in_ready_o/in_data_i    - operand stream
//   out_valid_o/out_ready_i/out_data_o - result stream
//   busy_o                    - not IDLE
//   done_o                    - pulse after last result handshake
//   err_o                     - pulse on start with an illegal dimension
module matrix_mult_stream
  import matrix_mult_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_DIM = 8,
  parameter int SIGNED  = 1,
  parameter int SHW     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [$clog2(MAX_DIM):0] dim_m_i,
  input  logic [$clog2(MAX_DIM):0] dim_k_i,
  input  logic [$clog2(MAX_DIM):0] dim_n_i,
  input  logic [SHW-1:0]           shift_i,
  input  logic                     sat_en_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DW-1:0]            in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DW-1:0]            out_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int DIM_W = dim_w(MAX_DIM);
  localparam int ACC_W = acc_w(DW, MAX_DIM);
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW    = 2 * DIM_W;  // width for products of two dims
  localparam logic [DIM_W-1:0]  D1   = DIM_W'(1);
  localparam logic [XW-1:0]     X1   = XW'(1);
  localparam logic [DIM_W-1:0]  DMAX = DIM_W'(MAX_DIM);
  localparam logic signed [63:0] SAT_HI = sat_hi(DW, SIGNED != 0);
  localparam logic signed [63:0] SAT_LO = sat_lo(DW, SIGNED != 0);

  function automatic logic [XW-1:0] zx(input logic [DIM_W-1:0] v);
    return {{DIM_W{1'b0}}, v};
  endfunction

  state_e             state_q;
  logic [DIM_W-1:0]   m_q, k_q, n_q;
  logic [SHW-1:0]     shift_q;
  logic               sat_q;
  logic [XW-1:0]      cnt_q;          // load word index, then drain read pointer
  logic [DIM_W-1:0]   ci_q, cj_q, ph_q;
  logic               out_valid_q;
  logic [DW-1:0]      out_data_q;
  logic               done_q, err_q;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] mem_c [DEPTH];
  logic [DW-1:0] a_rd_q, b_rd_q;

  logic [XW-1:0]    mk_w, kn_w, mn_w;
  logic [AW-1:0]    a_ra, b_ra, c_wa;
  logic             in_fire, last_in, dims_bad;
  logic             in_comp, mac_clr, mac_en, c_we, elem_end;
  logic [ACC_W-1:0] acc_val, sh_val;
  logic signed [63:0] sh64;
  logic [DW-1:0]    res_w;

  assign mk_w = zx(m_q) * zx(k_q);
  assign kn_w = zx(k_q) * zx(n_q);
  assign mn_w = zx(m_q) * zx(n_q);

  // Phase ph_q of element (ci,cj) reads A[ci][ph] and B[ph][cj]; reads past
  // k are harmless since the MAC ignores them.
  assign a_ra = AW'(zx(ci_q) * zx(k_q) + zx(ph_q));
  assign b_ra = AW'(zx(ph_q) * zx(n_q) + zx(cj_q));
  assign c_wa = AW'(zx(ci_q) * zx(n_q) + zx(cj_q));

  assign in_ready_o = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_fire    = in_valid_i && in_ready_o;
  assign last_in    = (state_q == LOAD_A) ? (cnt_q == mk_w - X1) : (cnt_q == kn_w - X1);

  assign dims_bad = (dim_m_i == '0) || (dim_k_i == '0) || (dim_n_i == '0) ||
                    (dim_m_i > DMAX) || (dim_k_i > DMAX) || (dim_n_i > DMAX);

  // Element schedule: phase 0 clears, phases 1..k accumulate the product of
  // the operands read one phase earlier, phase k+1 writes the result.
  assign in_comp  = (state_q == COMPUTE);
  assign elem_end = (ph_q == k_q + D1);
  assign mac_clr  = in_comp && (ph_q == '0);
  assign mac_en   = in_comp && (ph_q != '0) && (ph_q <= k_q);
  assign c_we     = in_comp && elem_end;

  mac_unit #(
    .DW     (DW),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .a_i     (a_rd_q),
    .b_i     (b_rd_q),
    .acc_o   (acc_val)
  );

  // Shift (arithmetic when signed, i.e. floor), then clamp or truncate.
  always_comb begin
    if (SIGNED != 0) begin
      sh_val = $unsigned($signed(acc_val) >>> shift_q);
      sh64   = {{(64-ACC_W){sh_val[ACC_W-1]}}, sh_val};
    end else begin
      sh_val = acc_val >> shift_q;
      sh64   = {{(64-ACC_W){1'b0}}, sh_val};
    end
    res_w = sh_val[DW-1:0];
    if (sat_q) begin
      if (sh64 > SAT_HI)      res_w = SAT_HI[DW-1:0];
      else if (sh64 < SAT_LO) res_w = SAT_LO[DW-1:0];
    end
  end

  // Memories: contents survive reset.
  always_ff @(posedge clk_i) begin
    if (in_fire && (state_q == LOAD_A)) mem_a[cnt_q[AW-1:0]] <= in_data_i;
    if (in_fire && (state_q == LOAD_B)) mem_b[cnt_q[AW-1:0]] <= in_data_i;
    if (c_we) mem_c[c_wa] <= res_w;
    a_rd_q <= mem_a[a_ra];
    b_rd_q <= mem_b[b_ra];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      ci_q        <= '0;
      cj_q        <= '0;
      ph_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (dims_bad) begin
              err_q <= 1'b1;
            end else begin
              m_q     <= dim_m_i;
              k_q     <= dim_k_i;
              n_q     <= dim_n_i;
              shift_q <= shift_i;
              sat_q   <= sat_en_i;
              cnt_q   <= '0;
              state_q <= LOAD_A;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (in_fire) begin
            if (last_in) begin
              cnt_q <= '0;
              if (state_q == LOAD_A) begin
                state_q <= LOAD_B;
              end else begin
                ci_q    <= '0;
                cj_q    <= '0;
                ph_q    <= '0;
                state_q <= COMPUTE;
              end
            end else begin
              cnt_q <= cnt_q + X1;
            end
          end
        end
        COMPUTE: begin
          if (elem_end) begin
            ph_q <= '0;
            if (cj_q == n_q - D1) begin
              cj_q <= '0;
              if (ci_q == m_q - D1) begin
                cnt_q   <= '0;
                state_q <= DRAIN;
              end else begin
                ci_q <= ci_q + D1;
              end
            end else begin
              cj_q <= cj_q + D1;
            end
          end else begin
            ph_q <= ph_q + D1;
          end
        end
        DRAIN: begin
          // cnt_q is the next word to fetch; once it reaches m*n the word on
          // the output is the last one.
          if (out_valid_q && out_ready_i && (cnt_q == mn_w)) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end else if ((!out_valid_q || out_ready_i) && (cnt_q != mn_w)) begin
            out_data_q  <= mem_c[cnt_q[AW-1:0]];
            out_valid_q <= 1'b1;
            cnt_q       <= cnt_q + X1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
